// File: rtl/fetch_pkg.sv
// Shared defaults and the queued entry layout for the fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 16;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_INDEX = '0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] index;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch queue bus: redirect input, icache read port and decode handshake.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W,
  parameter int unsigned DEPTH  = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_index;
  logic [ADDR_W-1:0] icache_index;
  logic              icache_not_enable;
  logic [DATA_W-1:0] icache_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_index;
  logic              instr_ready;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    input  redirect_valid, redirect_index, icache_data, instr_ready,
    output icache_index, icache_not_enable, instr_valid, instr_data, instr_index, fifo_count
  );

  modport slave (
    output redirect_valid, redirect_index, icache_data, instr_ready,
    input  icache_index, icache_not_enable, instr_valid, instr_data, instr_index, fifo_count
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; pointers wrap modulo DEPTH so any DEPTH works.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head_data,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Flush wins over any simultaneous push or pop.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    if (flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr);
      if (push && !pop)      count_nxt = count + CNT_W'(1);
      else if (pop && !push) count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch index owner: issues icache reads under a FIFO credit limit and
// queues returned halfwords for decode, with redirect flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W      = FETCH_ADDR_W,
  parameter int unsigned       DATA_W      = FETCH_DATA_W,
  parameter int unsigned       DEPTH       = 4,
  parameter logic [ADDR_W-1:0] RESET_INDEX = ADDR_W'(FETCH_RESET_INDEX)
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0]  fetch_index, fetch_index_nxt;
  logic [ADDR_W-1:0]  inflight_index, inflight_index_nxt;
  logic               inflight, inflight_nxt;
  logic               issue, push, pop;
  logic               head_valid, instr_valid_c;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_index    <= RESET_INDEX;
      inflight_index <= '0;
      inflight       <= 1'b0;
    end else begin
      fetch_index    <= fetch_index_nxt;
      inflight_index <= inflight_index_nxt;
      inflight       <= inflight_nxt;
    end
  end

  // Credit counts queued plus in-flight entries so a returning read always has a slot.
  always_comb begin
    issue = !rst && !bus.redirect_valid
            && ((32'(count) + 32'(inflight)) < DEPTH);
    push  = inflight && !bus.redirect_valid;

    fetch_index_nxt    = fetch_index;
    inflight_index_nxt = inflight_index;
    inflight_nxt       = issue;
    if (bus.redirect_valid) begin
      fetch_index_nxt = bus.redirect_index;
    end else if (issue) begin
      fetch_index_nxt    = fetch_index + ADDR_W'(1);
      inflight_index_nxt = fetch_index;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  ({inflight_index, bus.icache_data}),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .head_data  (head_entry),
    .head_valid (head_valid),
    .count      (count)
  );

  assign instr_valid_c         = head_valid && !bus.redirect_valid;
  assign pop                   = instr_valid_c && bus.instr_ready;

  assign bus.icache_index      = fetch_index;
  assign bus.icache_not_enable = !issue;
  assign bus.instr_valid       = instr_valid_c;
  assign bus.instr_index       = head_entry[ENTRY_W-1 -: ADDR_W];
  assign bus.instr_data        = head_entry[DATA_W-1:0];
  assign bus.fifo_count        = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] RST_IDX = 32'd10;

  logic clk = 1'b0;
  logic rst;

  fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .RESET_INDEX (RST_IDX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] icache_word(input logic [31:0] idx);
    logic [31:0] h;
    h = idx * 32'h9E3779B1;
    return h[31:16] ^ h[15:0];
  endfunction

  // Icache: one-cycle read latency; garbage when no read was issued.
  always @(posedge clk) begin
    if (!bus.icache_not_enable) bus.icache_data <= icache_word(bus.icache_index);
    else                        bus.icache_data <= 16'($urandom);
  end

  // Reference model: delivered stream as a queue, one outstanding read, next index.
  fetch_entry_t m_q[$];
  bit           m_inflight;
  logic [31:0]  m_inf_idx;
  logic [31:0]  m_fidx;
  int           n_vec;
  int           n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inflight = 1'b0;
    m_inf_idx  = '0;
    m_fidx     = RST_IDX;
  endtask

  function automatic bit model_issue();
    return !bus.redirect_valid && (m_q.size() + int'(m_inflight)) < int'(DEPTH);
  endfunction

  task automatic check_outputs();
    bit vld;
    bit iss;
    vld = !bus.redirect_valid && m_q.size() > 0;
    iss = model_issue();
    check("instr_valid", 64'(bus.instr_valid), 64'(vld));
    if (vld) begin
      check("instr_index", 64'(bus.instr_index), 64'(m_q[0].index));
      check("instr_data", 64'(bus.instr_data), 64'(m_q[0].data));
    end
    check("icache_not_enable", 64'(bus.icache_not_enable), 64'(!iss));
    if (iss) check("icache_index", 64'(bus.icache_index), 64'(m_fidx));
    check("fifo_count", 64'(bus.fifo_count), 64'(m_q.size()));
  endtask

  task automatic model_edge();
    bit iss;
    bit vld;
    iss = model_issue();
    vld = !bus.redirect_valid && m_q.size() > 0;
    if (bus.redirect_valid) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_fidx     = bus.redirect_index;
    end else begin
      if (vld && bus.instr_ready) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back('{m_inf_idx, icache_word(m_inf_idx)});
      if (iss) begin
        m_inf_idx = m_fidx;
        m_fidx    = m_fidx + 32'd1;
      end
      m_inflight = iss;
    end
  endtask

  task automatic cycle(input bit rv, input logic [31:0] ri, input bit rdy);
    bus.redirect_valid = rv;
    bus.redirect_index = ri;
    bus.instr_ready    = rdy;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      bit          rv;
      logic [31:0] ri;
      rv = ($urandom_range(0, 19) == 0);
      ri = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                       : (32'hFFFF_FFFF - 32'($urandom_range(0, 3)));
      cycle(rv, ri, $urandom_range(0, 9) < 7);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_index = '0;
    bus.instr_ready    = 1'b0;
    model_reset();
    #2;
    check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_not_enable", 64'(bus.icache_not_enable), 64'd1);
    check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    check("rst_icache_index", 64'(bus.icache_index), 64'(RST_IDX));
    #6 rst = 1'b0;

    // Streaming from reset, then backpressure to full and drain.
    repeat (10) cycle(1'b0, '0, 1'b1);
    repeat (10) cycle(1'b0, '0, 1'b0);
    repeat (8)  cycle(1'b0, '0, 1'b1);

    // Single redirect, back-to-back redirects, and index wrap.
    cycle(1'b1, 32'd7, 1'b1);
    repeat (8) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'd20, 1'b1);
    cycle(1'b1, 32'd40, 1'b1);
    repeat (8) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'hFFFF_FFFE, 1'b1);
    repeat (8) cycle(1'b0, '0, 1'b1);

    random_run(500);

    // Asynchronous reset mid-cycle with three queued entries and a read in flight.
    cycle(1'b1, 32'd100, 1'b0);
    for (int i = 0; i < 12 && m_q.size() != 3; i++) cycle(1'b0, '0, 1'b0);
    check("rst_setup_count", 64'(bus.fifo_count), 64'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("midrst_fifo_count", 64'(bus.fifo_count), 64'd0);
    check("midrst_not_enable", 64'(bus.icache_not_enable), 64'd1);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    model_edge();
    #1;
    repeat (12) cycle(1'b0, '0, 1'b1);
    random_run(150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
